io_arbiter: RTL and testbench

//  Shares the single J1 I/O slave bus (board_io and peers) between two requesters:

---
 rtl/io_arb_pkg.sv | 16 +
 rtl/io_arb_port.sv | 56 +++++
 rtl/io_arbiter.sv | 123 ++++++++++++
 tb/tb_io_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types for the J1 I/O bus arbiter: FSM states, buffered command record, port count.
package io_arb_pkg;

  localparam int unsigned NPORT = 2;
  localparam int unsigned IO_AW = 16;
  localparam int unsigned IO_DW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic             wr;
    logic [IO_AW-1:0] addr;
    logic [IO_DW-1:0] wdata;
  } io_cmd_t;

endpackage

// File: rtl/io_arb_port.sv
// One requester port: 1-deep command buffer with valid/ready and a held read-data register.
module io_arb_port
  import io_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             wr,
  input  logic [IO_AW-1:0] addr,
  input  logic [IO_DW-1:0] wdata,
  input  logic             clear,
  input  logic             capture_rdata,
  input  logic [IO_DW-1:0] rdata_in,
  output logic             ready,
  output logic             pend,
  output io_cmd_t          cmd,
  output logic [IO_DW-1:0] rdata
);

  logic             pend_d, pend_q;
  io_cmd_t          cmd_d, cmd_q;
  logic [IO_DW-1:0] rdata_d, rdata_q;

  // clear and a new accept never coincide: ready is low while the buffer is pending
  always_comb begin
    pend_d  = pend_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    if (clear) pend_d = 1'b0;
    if (valid && !pend_q) begin
      pend_d       = 1'b1;
      cmd_d.wr     = wr;
      cmd_d.addr   = addr;
      cmd_d.wdata  = wdata;
    end
    if (capture_rdata) rdata_d = rdata_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= 1'b0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = ~pend_q;
  assign pend  = pend_q;
  assign cmd   = cmd_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the J1 I/O slave bus between the CPU (port 0) and an aux master (port 1).
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned AW = IO_AW,
  parameter int unsigned DW = IO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          io_rd,
  output logic          io_wr,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_dout,
  input  logic [DW-1:0] io_din
);

  state_t           state_d, state_q;
  logic             sel_d, sel_q;
  logic             last_d, last_q;
  logic             io_rd_d, io_rd_q, io_wr_d, io_wr_q;
  logic [AW-1:0]    io_addr_d, io_addr_q;
  logic [DW-1:0]    io_dout_d, io_dout_q;
  logic [NPORT-1:0] done_d, done_q;
  logic [NPORT-1:0] pend, clear, cap;
  io_cmd_t          cmd [NPORT];
  io_cmd_t          cmd_sel;

  io_arb_port u_port0 (
    .clk(clk), .reset(reset), .valid(m0_valid), .wr(m0_wr), .addr(m0_addr), .wdata(m0_wdata),
    .clear(clear[0]), .capture_rdata(cap[0]), .rdata_in(io_din),
    .ready(m0_ready), .pend(pend[0]), .cmd(cmd[0]), .rdata(m0_rdata)
  );

  io_arb_port u_port1 (
    .clk(clk), .reset(reset), .valid(m1_valid), .wr(m1_wr), .addr(m1_addr), .wdata(m1_wdata),
    .clear(clear[1]), .capture_rdata(cap[1]), .rdata_in(io_din),
    .ready(m1_ready), .pend(pend[1]), .cmd(cmd[1]), .rdata(m1_rdata)
  );

  assign cap[0]   = (state_q == ISSUE) && io_rd_q && !sel_q;
  assign cap[1]   = (state_q == ISSUE) && io_rd_q &&  sel_q;
  assign clear[0] = (state_q == RESP) && !sel_q;
  assign clear[1] = (state_q == RESP) &&  sel_q;

  // Strobes are loaded on the IDLE->ISSUE edge so they are pure flop outputs during ISSUE
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    io_rd_d   = 1'b0;
    io_wr_d   = 1'b0;
    io_addr_d = '0;
    io_dout_d = '0;
    done_d    = '0;
    cmd_sel   = '0;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          sel_d     = (pend[0] && pend[1]) ? ~last_q : pend[1];
          cmd_sel   = sel_d ? cmd[1] : cmd[0];
          io_wr_d   = cmd_sel.wr;
          io_rd_d   = ~cmd_sel.wr;
          io_addr_d = cmd_sel.addr;
          io_dout_d = cmd_sel.wr ? cmd_sel.wdata : '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        done_d[sel_q] = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      io_addr_q <= '0;
      io_dout_q <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      io_addr_q <= io_addr_d;
      io_dout_q <= io_dout_d;
      done_q    <= done_d;
    end
  end

  assign io_rd   = io_rd_q;
  assign io_wr   = io_wr_q;
  assign io_addr = io_addr_q;
  assign io_dout = io_dout_q;
  assign m0_done = done_q[0];
  assign m1_done = done_q[1];

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: directed vector table, hand-written corner sequences, random run vs queue model.
module tb_io_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m0_wr, m0_done;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_wr, m1_done;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;

  logic        use_fn;
  logic [15:0] din_fix;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] slave_fn(input logic [15:0] a);
    return {a[3:0], a[15:4]} ^ 16'hC3A5;
  endfunction

  assign io_din = !io_rd ? 16'h0000 : (use_fn ? slave_fn(io_addr) : din_fix);

  io_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input logic v, input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    if (p) begin m1_valid = v; m1_wr = w; m1_addr = a; m1_wdata = d; end
    else   begin m0_valid = v; m0_wr = w; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic do_txn(input vec_t v);
    @(posedge clk); #1;
    din_fix = v.din;
    drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
    @(negedge clk);
    check("txn_ready_before", 32'(v.port ? m1_ready : m0_ready), 32'(1));
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("txn_idle_no_strobe", 32'({io_rd, io_wr}), 32'(0));
    @(negedge clk);
    check("txn_strobe", 32'({io_rd, io_wr}), v.wr ? 32'(1) : 32'(2));
    check("txn_addr", 32'(io_addr), 32'(v.addr));
    check("txn_dout", 32'(io_dout), 32'(v.exp_dout));
    @(negedge clk);
    check("txn_done", 32'({m1_done, m0_done}), v.port ? 32'(2) : 32'(1));
    check("txn_rdata", 32'(v.port ? m1_rdata : m0_rdata), 32'(v.exp_rdata));
    @(negedge clk);
    check("txn_done_clear", 32'({m1_done, m0_done}), 32'(0));
    check("txn_ready_after", 32'(v.port ? m1_ready : m0_ready), 32'(1));
  endtask

  // ---------------- random-phase reference model ----------------
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stamp;
  } mcmd_t;

  mcmd_t       mq [2][$];
  logic [15:0] mrdata [2];
  int          mn;
  int          last_strobe;
  int          gport;
  int          last_port;
  bit          busy;

  task automatic model_clear();
    mq[0].delete(); mq[1].delete();
    mrdata[0] = '0; mrdata[1] = '0;
    mn = 0; last_strobe = -100; gport = 0; last_port = 1; busy = 1'b0;
  endtask

  // Each buffered command is eligible one full cycle after its accept; the bus serves one
  // command every three cycles at most and prefers the port not served last when both wait.
  task automatic model_step();
    logic        rdy [2];
    logic [1:0]  exp_done;
    bit          cand [2];
    bit          exp_stb;
    mcmd_t       h;
    rdy[0] = m0_ready; rdy[1] = m1_ready;
    mn++;
    for (int p = 0; p < 2; p++)
      check("rnd_ready", 32'(rdy[p]), 32'(mq[p].size() == 0));
    check("rnd_exclusive", 32'(io_rd && io_wr), 32'(0));
    exp_done = '0;
    if (busy && mn == last_strobe + 1) exp_done[gport] = 1'b1;
    check("rnd_done", 32'({m1_done, m0_done}), 32'(exp_done));
    if (busy && mn == last_strobe + 1) begin
      h = mq[gport].pop_front();
      if (!h.wr) mrdata[gport] = slave_fn(h.addr);
      busy = 1'b0;
    end
    check("rnd_rdata0", 32'(m0_rdata), 32'(mrdata[0]));
    check("rnd_rdata1", 32'(m1_rdata), 32'(mrdata[1]));
    for (int p = 0; p < 2; p++)
      cand[p] = (mq[p].size() > 0) && (mq[p][0].stamp <= mn - 2);
    exp_stb = (mn - last_strobe >= 3) && (cand[0] || cand[1]);
    check("rnd_strobe", 32'(io_rd | io_wr), 32'(exp_stb));
    if (exp_stb && (io_rd | io_wr)) begin
      gport = (cand[0] && cand[1]) ? 1 - last_port : (cand[1] ? 1 : 0);
      h = mq[gport][0];
      check("rnd_kind", 32'({io_rd, io_wr}), h.wr ? 32'(1) : 32'(2));
      check("rnd_addr", 32'(io_addr), 32'(h.addr));
      check("rnd_dout", 32'(io_dout), h.wr ? 32'(h.wdata) : 32'(0));
      last_port = gport; last_strobe = mn; busy = 1'b1;
    end
    if (m0_valid && rdy[0]) mq[0].push_back('{m0_wr, m0_addr, m0_wdata, mn});
    if (m1_valid && rdy[1]) mq[1].push_back('{m1_wr, m1_addr, m1_wdata, mn});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   ns, n0, n1, nacc, nstb, late;
    bit   a0, a1;
    logic [15:0] exp_a;

    vecs[0] = '{1'b0, 1'b1, 16'h0004, 16'h00A5, 16'h0000, 16'h00A5, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h02F3, 16'h0000, 16'h02F3};
    vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'hFFFF, 16'h1234, 16'h02F3};
    vecs[3] = '{1'b0, 1'b0, 16'h0FFF, 16'h5555, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4] = '{1'b0, 1'b1, 16'hF123, 16'h0000, 16'h1111, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};

    reset = 1'b0; use_fn = 1'b0; din_fix = '0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    model_clear();
    do_reset();

    @(negedge clk);
    check("reset_ready", 32'({m1_ready, m0_ready}), 32'(3));
    check("reset_strobes", 32'({io_rd, io_wr, m1_done, m0_done}), 32'(0));
    check("reset_bus", 32'({io_addr, io_dout}), 32'(0));
    check("reset_rdata", 32'({m1_rdata, m0_rdata}), 32'(0));

    foreach (vecs[i]) do_txn(vecs[i]);

    // simultaneous start then back-to-back demand on both ports
    do_reset();
    ns = 0; n0 = 0; n1 = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h0100, 16'hA000);
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'hB000);
    for (int c = 0; c < 200 && ns < 20; c++) begin
      @(negedge clk);
      if (io_rd || io_wr) begin
        exp_a = 16'((ns % 2 + 1) * 256 + ns / 2);
        check("alt_order", 32'(io_addr), 32'(exp_a));
        ns++;
      end
      a0 = m0_valid && m0_ready;
      a1 = m1_valid && m1_ready;
      @(posedge clk); #1;
      if (a0) begin
        n0++;
        if (n0 < 10) drive(1'b0, 1'b1, n0[0], 16'(16'h0100 + n0), 16'(16'hA000 + n0));
        else         drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      if (a1) begin
        n1++;
        if (n1 < 10) drive(1'b1, 1'b1, n1[0], 16'(16'h0200 + n1), 16'(16'hB000 + n1));
        else         drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    check("alt_strobe_count", 32'(ns), 32'(20));
    check("alt_accepts", 32'({n1[7:0], n0[7:0]}), 32'({8'd10, 8'd10}));
    repeat (4) @(negedge clk);

    // m0_valid held high: ready/strobe/done follow a fixed 4-cycle rhythm
    nacc = 0; nstb = 0; late = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("hold_timeline", 32'({m0_ready, io_rd | io_wr, m0_done}),
            32'({k % 4 == 0, k % 4 == 2, k % 4 == 3}));
      if (m0_ready) nacc++;
      if (io_rd | io_wr) nstb++;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (io_rd | io_wr) late++;
    end
    check("hold_one_strobe_per_accept", 32'(nstb), 32'(nacc));
    check("hold_no_extra_after_drop", 32'(late), 32'(0));

    // reset asserted mid-ISSUE
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_strobe", 32'(io_rd), 32'(1));
    #1 reset = 1'b1;
    #1 check("rst_async_drop", 32'({io_rd, io_wr}), 32'(0));
    @(negedge clk); reset = 1'b0;
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m0_done | m1_done | io_rd | io_wr) late++;
    end
    check("rst_no_done", 32'(late), 32'(0));
    check("rst_ready_after", 32'({m1_ready, m0_ready}), 32'(3));

    // random traffic against the queue model
    use_fn = 1'b1;
    do_reset();
    model_clear();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
      drive(1'b1, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
      @(negedge clk);
      model_step();
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      model_step();
    end
    check("rnd_drained", 32'(mq[0].size() + mq[1].size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
